// File: rtl/vec_hazard_pkg.sv
// vec_hazard_pkg: shared types and defaults for the vector pipeline hazard scheduler
package vec_hazard_pkg;
  localparam int REG_AW_DEFAULT = 4;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10} fwd_sel_t;
  typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT, FAULT} hs_state_t;
endpackage

// File: rtl/hazard_fwd_sel.sv
// hazard_fwd_sel: forward select for one execute-stage operand, M stage has priority over W
module hazard_fwd_sel
  import vec_hazard_pkg::*;
#(
  parameter int AW = REG_AW_DEFAULT
) (
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] WA3M,
  input  logic [AW-1:0] WA3W,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  output fwd_sel_t      sel
);
  assign sel = (RegWriteM && WA3M == ra) ? FWD_MEM :
               (RegWriteW && WA3W == ra) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: 5-stage vector pipeline stall/flush/forward control with memory watchdog; HAZARD_PERF_CNT_EN adds stall counters
module hazard_scheduler
  import vec_hazard_pkg::*;
#(
  parameter int REG_AW  = REG_AW_DEFAULT,
  parameter int TIMEOUT = 255
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [REG_AW-1:0] ra1D,
  input  logic [REG_AW-1:0] ra2D,
  input  logic [REG_AW-1:0] ra1E,
  input  logic [REG_AW-1:0] ra2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              MemtoRegE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              mem_req_m,
  input  logic              mem_ready,
  output logic              EN1,
  output logic              EN2,
  output logic              CLR2,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              stall_all,
  output logic              busy,
  output logic              fault
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0]   lu_stalls
`endif
);
  localparam int WCW = $clog2(TIMEOUT + 1);
  hs_state_t      state;
  logic [WCW-1:0] wait_cnt;
  fwd_sel_t       fa, fb;
  logic           ms, lu, act, lub;
  hazard_fwd_sel #(.AW(REG_AW)) u_fwd_a (
    .ra(ra1E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .sel(fa)
  );
  hazard_fwd_sel #(.AW(REG_AW)) u_fwd_b (
    .ra(ra2E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .sel(fb)
  );
  assign ms  = mem_req_m & ~mem_ready;
  assign lu  = MemtoRegE & ((WA3E == ra1D) | (WA3E == ra2D));
  assign act = (state == RUN) || (state == MEM_WAIT);
  // a frozen E stage cannot take a bubble, so the memory stall masks the load-use flush
  assign lub = (state == RUN) && lu && !ms;
  always_comb begin
    stall_all = (state == FAULT) || (act && ms);
    EN1       = act && !ms && !lub;
    EN2       = EN1;
    CLR2      = (state == IDLE) || lub;
    ForwardAE = act ? fa : FWD_RF;
    ForwardBE = act ? fb : FWD_RF;
    busy      = act;
    fault     = state == FAULT;
  end
  always_ff @(posedge CLK)
    if (RST) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else
      case (state)
        IDLE: if (start) state <= RUN;
        RUN: if (ms) begin
          state    <= MEM_WAIT;
          wait_cnt <= '0;
        end
        MEM_WAIT: if (mem_ready) begin
          state    <= RUN;
          wait_cnt <= '0;
        end else if (wait_cnt == WCW'(TIMEOUT - 1)) state <= FAULT;
        else wait_cnt <= wait_cnt + 1'b1;
        default: ;
      endcase
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge CLK)
    if (RST) begin
      stall_cycles <= '0;
      lu_stalls    <= '0;
    end else begin
      if (stall_all && !(&stall_cycles)) stall_cycles <= stall_cycles + 1'b1;
      if (lub && !(&lu_stalls)) lu_stalls <= lu_stalls + 1'b1;
    end
`endif
endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler: directed checks of reset, forwarding, load-use, memory wait, timeout and perf counters
module tb_hazard_scheduler;
  logic       CLK = 1'b0, RST = 1'b1, start = 1'b0;
  logic [3:0] ra1D = '0, ra2D = '0, ra1E = '0, ra2E = '0, WA3E = '0, WA3M = '0, WA3W = '0;
  logic       MemtoRegE = 1'b0, RegWriteM = 1'b0, RegWriteW = 1'b0, mem_req_m = 1'b0, mem_ready = 1'b0;
  logic       EN1, EN2, CLR2, stall_all, busy, fault;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [3:0] stall_cycles, lu_stalls;
`endif
  int total = 0, fails = 0;
  always #5 CLK = ~CLK;
  hazard_scheduler #(.REG_AW(4), .TIMEOUT(8)
`ifdef HAZARD_PERF_CNT_EN
    , .CNT_W(4)
`endif
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .ra1D(ra1D), .ra2D(ra2D), .ra1E(ra1E), .ra2E(ra2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .mem_req_m(mem_req_m), .mem_ready(mem_ready), .EN1(EN1), .EN2(EN2),
    .CLR2(CLR2), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .stall_all(stall_all),
    .busy(busy), .fault(fault)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .lu_stalls(lu_stalls)
`endif
  );
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    RST = 1'b0;
    ra1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1;
    #1;
    chk("idle_en1", EN1, 0);
    chk("idle_en2", EN2, 0);
    chk("idle_clr2", CLR2, 1);
    chk("idle_busy", busy, 0);
    chk("idle_fault", fault, 0);
    chk("idle_stall", stall_all, 0);
    chk("idle_fwda", ForwardAE, 2'b00);
    tick();
    chk("idle_hold_clr2", CLR2, 1);
    chk("idle_hold_en1", EN1, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    WA3W = 4'd3; RegWriteW = 1'b1; ra2E = 4'd5;
    #1;
    chk("run_en1", EN1, 1);
    chk("run_en2", EN2, 1);
    chk("run_busy", busy, 1);
    chk("run_clr2", CLR2, 0);
    chk("fwd_a_mem", ForwardAE, 2'b10);
    chk("fwd_b_none", ForwardBE, 2'b00);
    RegWriteM = 1'b0;
    #1;
    chk("fwd_a_wb", ForwardAE, 2'b01);
    ra2E = 4'd0; WA3M = 4'd0; RegWriteM = 1'b1;
    #1;
    chk("fwd_b_r0_mem", ForwardBE, 2'b10);
    chk("fwd_a_wb_only", ForwardAE, 2'b01);
    RegWriteM = 1'b0; RegWriteW = 1'b0;
    tick();
    MemtoRegE = 1'b1; WA3E = 4'd7; ra2D = 4'd7;
    #1;
    chk("lu_en1", EN1, 0);
    chk("lu_en2", EN2, 0);
    chk("lu_clr2", CLR2, 1);
    tick();
    MemtoRegE = 1'b0;
    #1;
    chk("post_lu_en1", EN1, 1);
    chk("post_lu_clr2", CLR2, 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_lu_one", lu_stalls, 1);
`endif
    for (int i = 0; i < 4; i++) begin
      mem_req_m = 1'b1; mem_ready = 1'b0; MemtoRegE = (i > 0);
      #1;
      chk("mw_stall", stall_all, 1);
      chk("mw_clr2", CLR2, 0);
      chk("mw_en1", EN1, 0);
      chk("mw_busy", busy, 1);
      tick();
    end
    MemtoRegE = 1'b0; mem_ready = 1'b1;
    #1;
    chk("mw_ready_stall", stall_all, 0);
    chk("mw_ready_en1", EN1, 1);
    tick();
    mem_req_m = 1'b0; mem_ready = 1'b0; MemtoRegE = 1'b1;
    #1;
    chk("mw_back_run_lu", CLR2, 1);
    chk("mw_back_run_busy", busy, 1);
    tick();
    MemtoRegE = 1'b0;
    for (int i = 0; i < 9; i++) begin
      mem_req_m = 1'b1;
      #1;
      chk("to_nofault", fault, 0);
      chk("to_stall", stall_all, 1);
      tick();
    end
    #1;
    chk("to_fault", fault, 1);
    chk("to_busy", busy, 0);
    chk("to_stall_f", stall_all, 1);
    chk("to_en1", EN1, 0);
    chk("to_clr2", CLR2, 0);
    mem_ready = 1'b1; start = 1'b1; ra1E = 4'd3; WA3M = 4'd3; RegWriteM = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    #1;
    chk("fault_sticky", fault, 1);
    chk("fault_fwda", ForwardAE, 2'b00);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_stall_sat", stall_cycles, 15);
    chk("perf_lu_total", lu_stalls, 2);
`endif
    start = 1'b0; mem_req_m = 1'b0; mem_ready = 1'b0; RegWriteM = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    #1;
    chk("rst_fault", fault, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clr2", CLR2, 1);
    chk("rst_stall", stall_all, 0);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_perf_stall", stall_cycles, 0);
    chk("rst_perf_lu", lu_stalls, 0);
`endif
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
